spi_slave_core: RTL and testbench
=================================

// Module: spi_slave_core
// PURPOSE
//  Parametrised SPI slave, successor to the fixed mode-0 byte receiver. Supports all four
//  CPOL/CPHA modes, configurable word width and bit order, full-duplex TX with a holding
//  register, and back-to-back words within one SS assertion. Sits between the external
//  SPI master pins and the fabric command/data path; all fabric ports are in the clk domain.
// PARAMETERS
//  DATA_W      8      word width in bits (>=2)
//  CPOL        0      SCK idle level
//  CPHA        0      0: sample on leading edge, shift on trailing; 1: shift leading, sample trailing
//  MSB_FIRST   1      1: MSB first on both MOSI and MISO; 0: LSB first
//  SYNC_STAGES 2      synchroniser flops on sck/mosi/ss (>=2)
//  TX_IDLE     all 1s word shifted out on TX underrun
// PORTS
//  clk        in   1       system clock; f_clk >= 8*f_sck
//  rst        in   1       synchronous, active-high reset
//  ss         in   1       slave select, active low (async pin)
//  sck        in   1       SPI clock (async pin)
//  mosi       in   1       master out (async pin)
//  miso       out  1       slave out, registered
//  tx_data    in   DATA_W  word to transmit
//  tx_valid   in   1       tx_data valid
//  tx_ready   out  1       holding register empty; transfer when tx_valid&&tx_ready
//  rx_data    out  DATA_W  last received word, stable while rx_valid
//  rx_valid   out  1       received word pending; held until rx_ready
//  rx_ready   in   1       consumer pops rx_data when rx_valid&&rx_ready
//  busy       out  1       synchronised ss is low (frame active)
// BEHAVIOUR
//  Reset: miso=1, rx_data=0, rx_valid=0, tx_ready=1, busy=0, counters 0, state IDLE.
//  Reset mid-frame aborts everything; block waits for ss high before accepting a new frame.
//  Edges detected on synchronised sck vs. its 1-cycle-delayed copy; mode decides which is sample/shift.
//  FSM: IDLE -> (ss_sync fall) LOAD -> SHIFT; SHIFT -> (ss_sync rise) IDLE; ss_sync high in any state -> IDLE.
//  LOAD (1 cycle): tx_shift <= holding reg if full (holding emptied, tx_ready=1 next cycle) else TX_IDLE.
//  CPHA=0: first bit on miso at end of LOAD; each shift edge presents next bit.
//  CPHA=1: first bit presented on first leading edge; each later shift edge presents next bit.
//  Sample edge: mosi_sync shifted into rx_shift (order per MSB_FIRST); bit_ct++ mod DATA_W.
//  Word boundary (DATA_W-th sample edge): rx word complete; tx_shift reloaded from holding/TX_IDLE
//  at the next shift edge, so the next word's first bit follows the last bit with no gap.
//  RX complete, rx_valid=0 or popped same cycle: rx_data<=word, rx_valid=1 next cycle.
//  RX complete, rx_valid=1 and no pop: word dropped, rx_data unchanged (overrun).
//  tx_ready = !hold_full, registered; no same-cycle refill of a holding reg drained that cycle.
//  ss rise mid-word: partial rx word discarded, no rx_valid; word in tx_shift lost (counted consumed);
//  holding register untouched; bit_ct=0; miso returns to 1.
//  IDLE: miso=1; sck edges ignored.
// CONFIGURATION
//  SPI_SLAVE_STATUS_EN defined: adds ports status_clr (in,1), overrun (out,1), underrun (out,1).
//   overrun sets on dropped RX word; underrun sets when TX_IDLE loaded (LOAD or boundary); both
//   sticky until status_clr=1 (clear wins over same-cycle set) or rst. Reset value 0.
//  Not defined: ports absent, no status logic; data-path behaviour identical.
// TESTING
//  Mode 0, DATA_W=8: tx 0x3C preloaded, master sends 0xA5 -> rx_data=0xA5, rx_valid=1, master reads 0x3C.
//  Modes 1,2,3 repeat 0xA5/0x3C -> identical results; no bit slip at 8x oversampling.
//  One frame, 3 words, only 2 tx words queued -> master reads w0,w1,0xFF; underrun=1 (STATUS_EN).
//  rx_ready=0, 2 words 0x11,0x22 received -> rx_data stays 0x11, overrun=1; status_clr -> overrun=0.
//  ss rises after 5 bits, then full word 0x5A -> only rx 0x5A reported, bit alignment correct.
//  DATA_W=16, MSB_FIRST=0: master sends 0x1234 LSB first -> rx_data=0x1234; rst mid-word -> reset values.

Source files
------------

// File: rtl/spi_slave_core.sv
// SPI slave: all four CPOL/CPHA modes, configurable width and bit order, TX holding register.
// Define SPI_SLAVE_STATUS_EN to add sticky overrun/underrun flags with a status_clr input.
module spi_slave_core #(
  parameter int                DATA_W      = 8,
  parameter int                CPOL        = 0,
  parameter int                CPHA        = 0,
  parameter int                MSB_FIRST   = 1,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_IDLE     = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
`ifdef SPI_SLAVE_STATUS_EN
  input  logic              status_clr,
  output logic              overrun,
  output logic              underrun,
`endif
  output logic              busy
);

  localparam int            CW       = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
  localparam logic          CPOL_B   = (CPOL != 0);
  localparam logic          CPHA_B   = (CPHA != 0);
  localparam logic          MSB_B    = (MSB_FIRST != 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, ss_sync_q, ss_sync_d, mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d, ss_prev_q, ss_prev_d, armed_q, armed_d;
  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          bit_ct_q, bit_ct_d;
  logic                   first_q, first_d;
  logic [DATA_W-1:0]      rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]      hold_q, hold_d, rx_data_q, rx_data_d;
  logic                   hold_full_q, hold_full_d, rx_valid_q, rx_valid_d, miso_q, miso_d;

  logic sck_s, ss_s, mosi_s, sck_rise, sck_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge, ss_fall, rx_complete, word_load;
  logic [DATA_W-1:0] load_word, tx_src;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_B ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] w);
    return MSB_B ? {w[DATA_W-2:0], 1'b1} : {1'b1, w[DATA_W-1:1]};
  endfunction

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  assign sck_s       = sck_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise    = sck_s & ~sck_prev_q;
  assign sck_fall    = ~sck_s & sck_prev_q;
  assign lead_edge   = CPOL_B ? sck_fall : sck_rise;
  assign trail_edge  = CPOL_B ? sck_rise : sck_fall;
  assign sample_edge = CPHA_B ? trail_edge : lead_edge;
  assign shift_edge  = CPHA_B ? lead_edge : trail_edge;
  // ss_prev only becomes 1 after a genuine high, so a reset mid-frame cannot fake a falling edge
  assign ss_fall     = ss_prev_q & ~ss_s;
  assign load_word   = hold_full_q ? hold_q : TX_IDLE;

  always_comb begin
    sck_prev_d  = sck_s;
    ss_prev_d   = ss_s;
    armed_d     = armed_q | ss_s;
    state_d     = state_q;
    bit_ct_d    = bit_ct_q;
    first_d     = first_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;
    rx_complete = 1'b0;
    word_load   = 1'b0;
    tx_src      = tx_shift_q;
    case (state_q)
      ST_IDLE: begin
        miso_d   = 1'b1;
        bit_ct_d = '0;
        if (ss_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        word_load = 1'b1;
        first_d   = 1'b1;
        if (CPHA_B) begin
          tx_shift_d = load_word;
        end else begin
          miso_d     = first_bit(load_word);
          tx_shift_d = drop_bit(load_word);
        end
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sample_edge) begin
          first_d    = 1'b0;
          rx_shift_d = MSB_B ? {rx_shift_q[DATA_W-2:0], mosi_s} : {mosi_s, rx_shift_q[DATA_W-1:1]};
          if (bit_ct_q == LAST_BIT) begin
            bit_ct_d    = '0;
            rx_complete = 1'b1;
          end else begin
            bit_ct_d = bit_ct_q + CW'(1);
          end
        end
        if (shift_edge) begin
          first_d = 1'b0;
          // First shift edge after a word boundary starts the next TX word with no gap
          if (bit_ct_q == '0 && !first_q) begin
            word_load = 1'b1;
            tx_src    = load_word;
          end
          miso_d     = first_bit(tx_src);
          tx_shift_d = drop_bit(tx_src);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (ss_s) begin
      state_d     = ST_IDLE;
      miso_d      = 1'b1;
      bit_ct_d    = '0;
      first_d     = 1'b0;
      rx_complete = 1'b0;
      word_load   = 1'b0;
    end
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    if (word_load && hold_full_q) hold_full_d = 1'b0;
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (rx_complete && (!rx_valid_q || rx_ready)) begin
      rx_data_d  = rx_shift_d;
      rx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= {SYNC_STAGES{CPOL_B}};
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= CPOL_B;
      ss_prev_q   <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      bit_ct_q    <= '0;
      first_q     <= 1'b0;
      rx_shift_q  <= '0;
      tx_shift_q  <= TX_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b1;
    end else begin
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      ss_prev_q   <= ss_prev_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_ct_q    <= bit_ct_d;
      first_q     <= first_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
    end
  end

`ifdef SPI_SLAVE_STATUS_EN
  logic overrun_q, overrun_d, underrun_q, underrun_d;

  always_comb begin
    overrun_d  = overrun_q | (rx_complete & rx_valid_q & ~rx_ready);
    underrun_d = underrun_q | (word_load & ~hold_full_q);
    if (status_clr) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign overrun  = overrun_q;
  assign underrun = underrun_q;
`endif

  assign miso     = miso_q;
  assign tx_ready = ~hold_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = armed_q & ~ss_s;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench: four 8-bit mode instances plus a 16-bit LSB-first instance, each driven by a task-based SPI master.
module tb_spi_slave_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] ss_v, sck_v, mosi_v, tx_valid_v, rx_ready_v;
  wire  [4:0] miso_v, tx_ready_v, rx_valid_v, busy_v;
  logic [7:0] tx_data8 [4];
  wire  [7:0] rx_data8 [4];
  logic [15:0] tx_data16;
  wire  [15:0] rx_data16;
`ifdef SPI_SLAVE_STATUS_EN
  logic [4:0] status_clr_v;
  wire  [4:0] overrun_v, underrun_v;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mode
    spi_slave_core #(
      .DATA_W(8), .CPOL(gi / 2), .CPHA(gi % 2), .MSB_FIRST(1), .SYNC_STAGES(2), .TX_IDLE(8'hFF)
    ) u_dut (
      .clk(clk), .rst(rst), .ss(ss_v[gi]), .sck(sck_v[gi]), .mosi(mosi_v[gi]), .miso(miso_v[gi]),
      .tx_data(tx_data8[gi]), .tx_valid(tx_valid_v[gi]), .tx_ready(tx_ready_v[gi]),
      .rx_data(rx_data8[gi]), .rx_valid(rx_valid_v[gi]), .rx_ready(rx_ready_v[gi]),
`ifdef SPI_SLAVE_STATUS_EN
      .status_clr(status_clr_v[gi]), .overrun(overrun_v[gi]), .underrun(underrun_v[gi]),
`endif
      .busy(busy_v[gi])
    );
  end

  spi_slave_core #(
    .DATA_W(16), .CPOL(0), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2), .TX_IDLE(16'hFFFF)
  ) u_w16 (
    .clk(clk), .rst(rst), .ss(ss_v[4]), .sck(sck_v[4]), .mosi(mosi_v[4]), .miso(miso_v[4]),
    .tx_data(tx_data16), .tx_valid(tx_valid_v[4]), .tx_ready(tx_ready_v[4]),
    .rx_data(rx_data16), .rx_valid(rx_valid_v[4]), .rx_ready(rx_ready_v[4]),
`ifdef SPI_SLAVE_STATUS_EN
    .status_clr(status_clr_v[4]), .overrun(overrun_v[4]), .underrun(underrun_v[4]),
`endif
    .busy(busy_v[4])
  );

  // stream[j*8+i] is bit i on the wire of word j, MSB first
  function automatic logic [63:0] enc8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[i]      = a[7-i];
      s[8 + i]  = b[7-i];
      s[16 + i] = c[7-i];
    end
    return s;
  endfunction

  function automatic logic [7:0] word8(input logic [63:0] s, input int j);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[7-i] = s[j*8 + i];
    return w;
  endfunction

  // Master: half SCK period = 4 clk cycles, all changes 2 ns after a clk rising edge
  task automatic spi_frame(input int m, input logic [63:0] mo, input int nbits, output logic [63:0] mi);
    logic cpol, cpha;
    cpol = (m == 2 || m == 3);
    cpha = (m == 1 || m == 3);
    mi = '0;
    @(posedge clk);
    #2;
    ss_v[m] = 1'b0;
    #80;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi_v[m] = mo[i];
        #40;
        mi[i] = miso_v[m];
        sck_v[m] = ~cpol;
        #40;
        sck_v[m] = cpol;
      end else begin
        sck_v[m] = ~cpol;
        mosi_v[m] = mo[i];
        #40;
        mi[i] = miso_v[m];
        sck_v[m] = cpol;
        #40;
      end
    end
    #80;
    ss_v[m] = 1'b1;
    #80;
  endtask

  task automatic push(input int m, input logic [15:0] d);
    int t;
    t = 0;
    @(negedge clk);
    while (!tx_ready_v[m] && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (tx_ready_v[m] !== 1'b1) begin
      n_bad++;
      $display("FAIL push_ready m=%0d got tx_ready=%b exp 1", m, tx_ready_v[m]);
    end
    if (m == 4) tx_data16 = d;
    else tx_data8[m] = d[7:0];
    tx_valid_v[m] = 1'b1;
    @(negedge clk);
    tx_valid_v[m] = 1'b0;
  endtask

  task automatic pop(input int m);
    @(negedge clk);
    rx_ready_v[m] = 1'b1;
    @(negedge clk);
    rx_ready_v[m] = 1'b0;
    n_cmp++;
    if (rx_valid_v[m] !== 1'b0) begin
      n_bad++;
      $display("FAIL pop m=%0d got rx_valid=%b exp 0", m, rx_valid_v[m]);
    end
  endtask

`ifdef SPI_SLAVE_STATUS_EN
  task automatic clr_status(input int m);
    @(negedge clk);
    status_clr_v[m] = 1'b1;
    @(negedge clk);
    status_clr_v[m] = 1'b0;
  endtask
`endif

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int m = 0; m < 5; m++) begin
      n_cmp++;
      if ({miso_v[m], rx_valid_v[m], tx_ready_v[m], busy_v[m]} !== 4'b1010) begin
        n_bad++;
        $display("FAIL reset_flags m=%0d got miso,rxv,txr,busy=%b%b%b%b exp 1010",
                 m, miso_v[m], rx_valid_v[m], tx_ready_v[m], busy_v[m]);
      end
      if (m < 4) begin
        n_cmp++;
        if (rx_data8[m] !== 8'h00) begin
          n_bad++;
          $display("FAIL reset_rx_data m=%0d got %h exp 00", m, rx_data8[m]);
        end
      end
    end
    n_cmp++;
    if (rx_data16 !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_rx_data16 got %h exp 0000", rx_data16);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_mode(input int m);
    logic [63:0] mi;
    push(m, 16'h003C);
    spi_frame(m, enc8(8'hA5, 8'h00, 8'h00), 8, mi);
    n_cmp++;
    if (rx_data8[m] !== 8'hA5) begin
      n_bad++;
      $display("FAIL mode%0d_rx_data got %h exp a5", m, rx_data8[m]);
    end
    n_cmp++;
    if (rx_valid_v[m] !== 1'b1) begin
      n_bad++;
      $display("FAIL mode%0d_rx_valid got %b exp 1", m, rx_valid_v[m]);
    end
    n_cmp++;
    if (word8(mi, 0) !== 8'h3C) begin
      n_bad++;
      $display("FAIL mode%0d_miso_word got %h exp 3c", m, word8(mi, 0));
    end
    pop(m);
    $display("test_mode m=%0d rx=%h master_read=%h", m, rx_data8[m], word8(mi, 0));
  endtask

  task automatic test_back_to_back_underrun();
    logic [63:0] mi;
`ifdef SPI_SLAVE_STATUS_EN
    clr_status(0);
    n_cmp++;
    if (underrun_v[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL underrun_clr got %b exp 0", underrun_v[0]);
    end
`endif
    rx_ready_v[0] = 1'b1;
    push(0, 16'h00C3);
    fork
      spi_frame(0, enc8(8'h01, 8'h02, 8'h03), 24, mi);
      begin
        repeat (20) @(posedge clk);
        push(0, 16'h0096);
      end
    join
    rx_ready_v[0] = 1'b0;
    n_cmp++;
    if ({word8(mi, 0), word8(mi, 1), word8(mi, 2)} !== 24'hC396FF) begin
      n_bad++;
      $display("FAIL b2b_miso got %h%h%h exp c396ff", word8(mi, 0), word8(mi, 1), word8(mi, 2));
    end
    n_cmp++;
    if (rx_data8[0] !== 8'h03) begin
      n_bad++;
      $display("FAIL b2b_rx_last got %h exp 03", rx_data8[0]);
    end
`ifdef SPI_SLAVE_STATUS_EN
    n_cmp++;
    if (underrun_v[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL underrun_set got %b exp 1", underrun_v[0]);
    end
`endif
    $display("test_back_to_back master_read=%h %h %h", word8(mi, 0), word8(mi, 1), word8(mi, 2));
  endtask

  task automatic test_overrun();
    logic [63:0] mi;
`ifdef SPI_SLAVE_STATUS_EN
    clr_status(0);
`endif
    rx_ready_v[0] = 1'b0;
    spi_frame(0, enc8(8'h11, 8'h22, 8'h00), 16, mi);
    n_cmp++;
    if (rx_data8[0] !== 8'h11) begin
      n_bad++;
      $display("FAIL overrun_rx_data got %h exp 11", rx_data8[0]);
    end
    n_cmp++;
    if (rx_valid_v[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_rx_valid got %b exp 1", rx_valid_v[0]);
    end
`ifdef SPI_SLAVE_STATUS_EN
    n_cmp++;
    if (overrun_v[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_set got %b exp 1", overrun_v[0]);
    end
    clr_status(0);
    n_cmp++;
    if (overrun_v[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_clr got %b exp 0", overrun_v[0]);
    end
`endif
    pop(0);
    $display("test_overrun rx=%h", rx_data8[0]);
  endtask

  task automatic test_abort();
    logic [63:0] mi;
    spi_frame(0, 64'h1F, 5, mi);
    n_cmp++;
    if ({rx_valid_v[0], miso_v[0], busy_v[0]} !== 3'b010) begin
      n_bad++;
      $display("FAIL abort_idle got rxv,miso,busy=%b%b%b exp 010", rx_valid_v[0], miso_v[0], busy_v[0]);
    end
    spi_frame(0, enc8(8'h5A, 8'h00, 8'h00), 8, mi);
    n_cmp++;
    if (rx_data8[0] !== 8'h5A || rx_valid_v[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_next_word got %h/%b exp 5a/1", rx_data8[0], rx_valid_v[0]);
    end
    pop(0);
    $display("test_abort rx=%h", rx_data8[0]);
  endtask

  task automatic test_wide_lsb();
    logic [63:0] mi;
    push(4, 16'hBEEF);
    spi_frame(4, 64'h1234, 16, mi);
    n_cmp++;
    if (rx_data16 !== 16'h1234 || rx_valid_v[4] !== 1'b1) begin
      n_bad++;
      $display("FAIL w16_rx got %h/%b exp 1234/1", rx_data16, rx_valid_v[4]);
    end
    n_cmp++;
    if (mi[15:0] !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL w16_miso got %h exp beef", mi[15:0]);
    end
    pop(4);
    $display("test_wide_lsb rx=%h master_read=%h", rx_data16, mi[15:0]);
  endtask

  task automatic test_reset_midword();
    logic [63:0] mi;
    fork
      spi_frame(4, 64'h00FF, 16, mi);
      begin
        repeat (20) @(posedge clk);
        push(4, 16'h2222);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (tx_ready_v[4] !== 1'b0) begin
          n_bad++;
          $display("FAIL midrst_pre_txready got %b exp 0", tx_ready_v[4]);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({miso_v[4], rx_valid_v[4], tx_ready_v[4], busy_v[4]} !== 4'b1010 || rx_data16 !== 16'h0000) begin
          n_bad++;
          $display("FAIL midrst_values got miso,rxv,txr,busy=%b%b%b%b rx=%h exp 1010 0000",
                   miso_v[4], rx_valid_v[4], tx_ready_v[4], busy_v[4], rx_data16);
        end
        rst = 1'b0;
      end
    join
    n_cmp++;
    if (rx_valid_v[4] !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_no_word got rx_valid=%b exp 0", rx_valid_v[4]);
    end
    spi_frame(4, 64'h0F0F, 16, mi);
    n_cmp++;
    if (rx_data16 !== 16'h0F0F || mi[15:0] !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL midrst_recover got rx=%h read=%h exp 0f0f ffff", rx_data16, mi[15:0]);
    end
    $display("test_reset_midword rx=%h master_read=%h", rx_data16, mi[15:0]);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    ss_v       = 5'b11111;
    sck_v      = 5'b01100;
    mosi_v     = '0;
    tx_valid_v = '0;
    rx_ready_v = '0;
    tx_data16  = '0;
    for (int i = 0; i < 4; i++) tx_data8[i] = '0;
`ifdef SPI_SLAVE_STATUS_EN
    status_clr_v = '0;
`endif
    test_reset();
    for (int m = 0; m < 4; m++) test_mode(m);
    test_back_to_back_underrun();
    test_overrun();
    test_abort();
    test_wide_lsb();
    test_reset_midword();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
